// File: rtl/exit_reporter_pkg.sv
// exit_reporter_pkg: shared state type, message constants and hex encoder for the exit reporter
package exit_reporter_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
   localparam int MSG_LEN = 15;
   localparam logic [7:0] CH_E  = 8'h45;
   localparam logic [7:0] CH_X  = 8'h58;
   localparam logic [7:0] CH_I  = 8'h49;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_EQ = 8'h3D;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready rises in the last stop-bit cycle so frames can run back to back
module uart_tx_byte
   import exit_reporter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 130
) (
   input  logic       clk_gen,
   input  logic       rst_n,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   state_t st;
   logic [W-1:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic last;
   assign last = baud == LAST;
   assign ready_o = st == IDLE || (st == STOP && last);
   always_ff @(posedge clk_gen or negedge rst_n)
      if (!rst_n) begin
         st <= IDLE;
         baud <= '0;
         bit_idx <= '0;
         sh <= '0;
         tx_o <= 1'b1;
      end else if (valid_i && ready_o) begin
         st <= START;
         baud <= '0;
         bit_idx <= '0;
         sh <= data_i;
         tx_o <= 1'b0;
      end else begin
         baud <= (st == IDLE || last) ? '0 : baud + 1'b1;
         if (last && st == START) begin
            st <= DATA;
            tx_o <= sh[0];
            sh <= sh >> 1;
         end else if (last && st == DATA) begin
            bit_idx <= bit_idx + 3'd1;
            st <= bit_idx == 3'd7 ? STOP : DATA;
            tx_o <= bit_idx == 3'd7 ? 1'b1 : sh[0];
            sh <= sh >> 1;
         end else if (last && st == STOP) st <= IDLE;
      end
endmodule

// File: rtl/exit_status_uart_reporter.sv
// exit_status_uart_reporter: reports each new exit event as "EXIT=hhhhhhhh\r\n" over UART and drives status LEDs
module exit_status_uart_reporter
   import exit_reporter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 130,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk_gen,
   input  logic        rst_n,
   input  logic        exit_valid_i,
   input  logic [31:0] exit_value_i,
   output logic        uart_tx_o,
   output logic        busy_o,
   output logic        done_led_o,
   output logic        pass_led_o
);
   state_t st;
   logic [3:0] idx, nxt;
   logic [31:0] cap;
   logic [SYNC_STAGES-1:0] sync;
   logic vld_q, trig, ready, valid;
   logic [7:0] ch;
   assign trig = sync[SYNC_STAGES-1] && !vld_q;
   assign nxt = st == IDLE ? 4'd0 : idx + 4'd1;
   assign valid = st == IDLE ? trig : (st == START && ready && idx != 4'(MSG_LEN - 1));
   // cap shifts left per hex digit, so its top nibble is always the next digit to send
   assign ch = nxt == 4'd0  ? CH_E  :
               nxt == 4'd1  ? CH_X  :
               nxt == 4'd2  ? CH_I  :
               nxt == 4'd3  ? CH_T  :
               nxt == 4'd4  ? CH_EQ :
               nxt == 4'd13 ? CH_CR :
               nxt == 4'd14 ? CH_LF : hex_ascii(cap[31:28]);
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk_gen(clk_gen),
      .rst_n(rst_n),
      .data_i(ch),
      .valid_i(valid),
      .ready_o(ready),
      .tx_o(uart_tx_o)
   );
   always_ff @(posedge clk_gen or negedge rst_n)
      if (!rst_n) begin
         sync <= '0;
         vld_q <= 1'b0;
         st <= IDLE;
         idx <= '0;
         cap <= '0;
         busy_o <= 1'b0;
         done_led_o <= 1'b0;
         pass_led_o <= 1'b0;
      end else begin
         sync <= SYNC_STAGES'({sync, exit_valid_i});
         vld_q <= sync[SYNC_STAGES-1];
         if (st == IDLE && trig) begin
            st <= START;
            idx <= '0;
            cap <= exit_value_i;
            busy_o <= 1'b1;
            pass_led_o <= exit_value_i == 32'd0;
         end else if (st == DONE) begin
            st <= IDLE;
            idx <= '0;
         end else if (st == START && ready) begin
            st <= valid ? START : DONE;
            idx <= nxt;
            busy_o <= valid;
            done_led_o <= done_led_o || !valid;
            if (nxt >= 4'd5 && nxt <= 4'd12) cap <= cap << 4;
         end
      end
endmodule
